// File: rtl/denise_bitplane_packer_if.sv
// Output word stream of the bitplane packer: left-aligned word, last-of-window
// flag and a valid/ready handshake.
interface denise_bitplane_packer_if;
    logic [63:0] data_out;
    logic        data_last;
    logic        data_valid;
    logic        data_ready;

    modport master (
        output data_out,
        output data_last,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_last,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/denise_bitplane_packer.sv
// Serial-to-parallel bitplane packer: strobed pixel bits are packed MSB-first
// into 16/32/64-bit words and queued in a 2-entry FIFO with a sticky overflow.
module denise_bitplane_packer #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        c1,
    input  logic        c3,
    input  logic        hires,
    input  logic        shres,
    input  logic [1:0]  fmode,
    input  logic        enable,
    input  logic [5:0]  skip,
    input  logic        pix_in,
    input  logic        clear_ovf,
    output logic        overflow,
    denise_bitplane_packer_if.master bus
);
    typedef enum logic [1:0] {IDLE, SKIP, COLLECT} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_en_d;
    logic [6:0]  r_n;
    logic [5:0]  r_skip;
    logic [5:0]  r_skip_cnt;
    logic [5:0]  r_bit_cnt;
    logic [63:0] r_asm;

    logic        w_stb, w_en_rise;
    logic        w_latch, w_skip_inc, w_shift, w_clr;
    logic        w_push, w_push_last;
    logic [63:0] w_push_data, w_asm_shift;
    logic [6:0]  w_bit_cnt_inc;

    logic [64:0] r_mem [FIFO_DEPTH];
    logic        r_rd_ptr, r_wr_ptr;
    logic [1:0]  r_fifo_cnt;
    logic        w_full, w_pop, w_wr, w_drop;

    function automatic logic [6:0] word_len(input logic [1:0] fm);
        case (fm)
            2'b00:   return 7'd16;
            2'b11:   return 7'd64;
            default: return 7'd32;
        endcase
    endfunction

    // Pixel strobe is qualified by enable so a sample coinciding with the falling edge is lost
    assign w_stb         = enable & (shres | (hires ? (~c1 ^ c3) : (~c1 & ~c3)));
    assign w_en_rise     = enable & ~r_en_d;
    assign w_asm_shift   = r_asm | (64'(pix_in) << (6'd63 - r_bit_cnt));
    assign w_bit_cnt_inc = {1'b0, r_bit_cnt} + 7'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_skip_inc  = 1'b0;
        w_shift     = 1'b0;
        w_clr       = 1'b0;
        w_push      = 1'b0;
        w_push_last = 1'b0;
        w_push_data = w_asm_shift;
        unique case (r_state)
            IDLE: begin
                if (w_en_rise) begin
                    w_latch     = 1'b1;
                    w_state_nxt = (skip != 6'd0) ? SKIP : COLLECT;
                end
            end
            SKIP: begin
                if (!enable) begin
                    w_state_nxt = IDLE;
                end else if (w_stb) begin
                    if (r_skip_cnt == r_skip - 6'd1) begin
                        w_state_nxt = COLLECT;
                    end else begin
                        w_skip_inc = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (!enable) begin
                    w_push      = (r_bit_cnt != 6'd0);
                    w_push_last = 1'b1;
                    w_push_data = r_asm;
                    w_clr       = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_stb) begin
                    w_shift = 1'b1;
                    if (w_bit_cnt_inc == r_n) begin
                        w_push = 1'b1;
                        w_clr  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Window control: latched word length/skip and the two counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_en_d     <= 1'b0;
            r_n        <= 7'd16;
            r_skip     <= 6'd0;
            r_skip_cnt <= 6'd0;
            r_bit_cnt  <= 6'd0;
        end else begin
            r_en_d <= enable;
            if (w_latch) begin
                r_n        <= word_len(fmode);
                r_skip     <= skip;
                r_skip_cnt <= 6'd0;
                r_bit_cnt  <= 6'd0;
            end else begin
                if (w_skip_inc) begin
                    r_skip_cnt <= r_skip_cnt + 6'd1;
                end
                if (w_clr) begin
                    r_bit_cnt <= 6'd0;
                end else if (w_shift) begin
                    r_bit_cnt <= r_bit_cnt + 6'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_latch || w_clr) begin
            r_asm <= '0;
        end else if (w_shift) begin
            r_asm <= w_asm_shift;
        end
    end

    // Output FIFO: a pop frees the head slot in the same cycle, so a full FIFO still accepts a push
    assign w_full  = (r_fifo_cnt == 2'(FIFO_DEPTH));
    assign w_pop   = bus.data_valid & bus.data_ready;
    assign w_wr    = w_push & (~w_full | w_pop);
    assign w_drop  = w_push & w_full & ~w_pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_fifo_cnt <= 2'd0;
            overflow   <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_wr, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
            if (w_drop) begin
                overflow <= 1'b1;
            end else if (clear_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {w_push_last, w_push_data};
        end
    end

    assign bus.data_valid = (r_fifo_cnt != 2'd0);
    assign bus.data_out   = bus.data_valid ? r_mem[r_rd_ptr][63:0] : 64'd0;
    assign bus.data_last  = bus.data_valid ? r_mem[r_rd_ptr][64]   : 1'b0;
endmodule

// File: tb/tb_denise_bitplane_packer.sv
// Scoreboard bench for denise_bitplane_packer: a bit-list window model predicts
// each word; a negedge monitor compares whatever the FIFO head presents.
module tb_denise_bitplane_packer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        c1 = 1'b0, c3 = 1'b0, hires = 1'b0, shres = 1'b0;
    logic [1:0]  fmode = 2'b00;
    logic        enable = 1'b0;
    logic [5:0]  skip = 6'd0;
    logic        pix_in = 1'b0, clear_ovf = 1'b0;
    logic        overflow;

    denise_bitplane_packer_if bus();

    denise_bitplane_packer #(.FIFO_DEPTH(2)) dut (
        .clk(clk), .reset_n(reset_n), .c1(c1), .c3(c3), .hires(hires), .shres(shres),
        .fmode(fmode), .enable(enable), .skip(skip), .pix_in(pix_in),
        .clear_ovf(clear_ovf), .overflow(overflow), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int phase    = 0;

    logic [64:0] q[$];
    logic [64:0] popped[$];
    bit          m_bits[$];
    bit          m_active = 0, m_prev_en = 0, m_ovf = 0;
    int          m_n = 16, m_skip_left = 0;

    task automatic chk(input string name, input logic [64:0] got, input logic [64:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic logic [1:0] phase_bits(input int ph);
        case (ph % 4)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    function automatic bit strobe_for(input int ph);
        logic [1:0] b;
        b = phase_bits(ph);
        if (shres) return 1'b1;
        if (hires) return (b[1] == b[0]);
        return (b == 2'b00);
    endfunction

    function automatic logic [63:0] pack_bits();
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < m_bits.size(); i++) w[63-i] = m_bits[i];
        return w;
    endfunction

    // One clock: drive inputs, predict the edge with the window model, commit after the edge
    task automatic cycle(input bit en, input bit pix, input bit rdy, input bit clr);
        bit stb, pop, has_word, drop;
        logic [64:0] w;
        phase++;
        {c1, c3} = phase_bits(phase);
        enable = en; pix_in = pix; bus.data_ready = rdy; clear_ovf = clr;
        stb = strobe_for(phase);
        pop = rdy && (q.size() > 0);
        has_word = 0;
        w = '0;
        if (!m_active) begin
            if (en && !m_prev_en) begin
                m_active = 1;
                m_n = (fmode == 2'b00) ? 16 : (fmode == 2'b11) ? 64 : 32;
                m_skip_left = skip;
                m_bits.delete();
            end
        end else if (!en) begin
            if (m_bits.size() > 0) begin
                has_word = 1;
                w = {1'b1, pack_bits()};
            end
            m_bits.delete();
            m_active = 0;
        end else if (stb) begin
            if (m_skip_left > 0) begin
                m_skip_left--;
            end else begin
                m_bits.push_back(pix);
                if (m_bits.size() == m_n) begin
                    has_word = 1;
                    w = {1'b0, pack_bits()};
                    m_bits.delete();
                end
            end
        end
        m_prev_en = en;
        drop = has_word && (q.size() >= 2) && !pop;
        if (drop) m_ovf = 1;
        else if (clr) m_ovf = 0;
        @(posedge clk);
        if (has_word && !drop) q.push_back(w);
        #1;
        chk("overflow", {64'd0, overflow}, {64'd0, m_ovf});
    endtask

    task automatic feed(input int nstb, input int junk, input logic [63:0] pat,
                        input int k0, input int rdy_mode, input bit wiggle);
        int k, guard;
        bit s, pix, rdy, clr;
        k = k0;
        guard = 0;
        while (k < k0 + nstb && guard < 8 * nstb + 8) begin
            if (wiggle && $urandom_range(0, 15) == 0) begin
                hires = 1'($urandom); shres = 1'($urandom); fmode = 2'($urandom);
            end
            s = strobe_for(phase + 1);
            pix = 1'($urandom);
            if (s && k >= junk) pix = pat[63 - ((k - junk) % 64)];
            rdy = (rdy_mode == 2) ? 1'($urandom) : (rdy_mode == 1);
            clr = (rdy_mode == 2) && ($urandom_range(0, 9) == 0);
            cycle(1'b1, pix, rdy, clr);
            if (s) k++;
            guard++;
        end
    endtask

    task automatic window(input bit sh, input bit hi, input logic [1:0] fm, input logic [5:0] sk,
                          input int nstb, input int junk, input logic [63:0] pat,
                          input int rdy_mode, input bit wiggle);
        shres = sh; hires = hi; fmode = fm; skip = sk;
        cycle(1'b1, 1'($urandom), (rdy_mode == 2) ? 1'($urandom) : (rdy_mode == 1), 1'b0);
        feed(nstb, junk, pat, 0, rdy_mode, wiggle);
        cycle(1'b0, 1'($urandom), (rdy_mode == 2) ? 1'($urandom) : (rdy_mode == 1), 1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 300) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0);
            n++;
        end
        chk("drain_empty", 65'(q.size()), 65'd0);
    endtask

    // Monitor: FIFO head must match the scoreboard head at every cycle
    always @(negedge clk) begin
        if (reset_n) begin
            chk("data_valid", {64'd0, bus.data_valid}, {64'd0, (q.size() > 0)});
            if (bus.data_valid && q.size() > 0) begin
                chk("data_out", {1'b0, bus.data_out}, {1'b0, q[0][63:0]});
                chk("data_last", {64'd0, bus.data_last}, {64'd0, q[0][64]});
                if (bus.data_ready) begin
                    popped.push_back(q[0]);
                    void'(q.pop_front());
                end
            end else if (!bus.data_valid) begin
                chk("data_out_idle", {1'b0, bus.data_out}, 65'd0);
            end
        end
    end

    initial begin
        bus.data_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {64'd0, bus.data_valid}, 65'd0);
        chk("rst_data", {1'b0, bus.data_out}, 65'd0);
        chk("rst_last", {64'd0, bus.data_last}, 65'd0);
        chk("rst_ovf", {64'd0, overflow}, 65'd0);
        reset_n = 1'b1;

        // shres 16-bit alternating pattern
        popped.delete();
        window(1, 0, 2'b00, 6'd0, 16, 0, 64'hAAAA_AAAA_AAAA_AAAA, 1, 0);
        drain();
        chk("t1_count", 65'(popped.size()), 65'd1);
        chk("t1_word", popped[0], {1'b0, 64'hAAAA_0000_0000_0000});

        // lores 64-bit with three skipped samples
        popped.delete();
        window(0, 0, 2'b11, 6'd3, 67, 3, 64'hDEAD_BEEF_CAFE_F00D, 1, 0);
        drain();
        chk("t2_count", 65'(popped.size()), 65'd1);
        chk("t2_word", popped[0], {1'b0, 64'hDEAD_BEEF_CAFE_F00D});

        // hires 32-bit, partial final word
        popped.delete();
        window(0, 1, 2'b01, 6'd0, 40, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
        drain();
        chk("t3_count", 65'(popped.size()), 65'd2);
        chk("t3_word0", popped[0], {1'b0, 64'hFFFF_FFFF_0000_0000});
        chk("t3_word1", popped[1], {1'b1, 64'hFF00_0000_0000_0000});

        // FIFO full, third word dropped, overflow set then cleared
        popped.delete();
        window(1, 0, 2'b00, 6'd0, 48, 0, 64'h1234_5678_9ABC_DEF0, 0, 0);
        chk("t4_ovf_set", {64'd0, overflow}, 65'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t4_ovf_clr", {64'd0, overflow}, 65'd0);
        drain();
        chk("t4_count", 65'(popped.size()), 65'd2);
        chk("t4_word0", popped[0], {1'b0, 64'h1234_0000_0000_0000});
        chk("t4_word1", popped[1], {1'b0, 64'h5678_0000_0000_0000});

        // Full FIFO with a pop in the cycle the third word completes
        popped.delete();
        shres = 1; hires = 0; fmode = 2'b00; skip = 6'd0;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        feed(47, 0, 64'h1234_5678_9ABC_DEF0, 0, 0, 0);
        feed(1, 0, 64'h1234_5678_9ABC_DEF0, 47, 1, 0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        drain();
        chk("t5_ovf", {64'd0, overflow}, 65'd0);
        chk("t5_count", 65'(popped.size()), 65'd3);
        chk("t5_word2", popped[2], {1'b0, 64'h9ABC_0000_0000_0000});

        // Reset mid-collect with one word queued
        shres = 1; hires = 0; fmode = 2'b00; skip = 6'd0;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        feed(20, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0);
        reset_n = 1'b0;
        #1;
        chk("t6_valid", {64'd0, bus.data_valid}, 65'd0);
        chk("t6_ovf", {64'd0, overflow}, 65'd0);
        chk("t6_data", {1'b0, bus.data_out}, 65'd0);
        q.delete();
        m_bits.delete();
        m_active = 0; m_prev_en = 0; m_ovf = 0;
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        popped.delete();
        window(1, 0, 2'b00, 6'd0, 32, 0, 64'h0123_4567_89AB_CDEF, 1, 0);
        drain();
        chk("t6_count", 65'(popped.size()), 65'd2);
        chk("t6_word0", popped[0], {1'b0, 64'h0123_0000_0000_0000});
        chk("t6_word1", popped[1], {1'b0, 64'h4567_0000_0000_0000});

        // Randomised windows against the model
        for (int w = 0; w < 40; w++) begin
            logic [5:0] sk;
            sk = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 4));
            window(1'($urandom), 1'($urandom), 2'($urandom), sk, $urandom_range(0, 140), int'(sk),
                   {$urandom, $urandom}, ($urandom_range(0, 2) == 0) ? 1 : 2,
                   ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 2)) cycle(1'b0, 1'b0, 1'($urandom), 1'b0);
        end
        drain();
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        chk("final_valid", {64'd0, bus.data_valid}, 65'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
